// File: rtl/mem_pkg.sv
// Shared constants and access-legality check for the data memory stage.
// Provides the RV32I funct3 size/sign encodings and one check that both
// the load and store paths use, so they cannot disagree on what is legal.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when funct3 is a legal encoding for this access kind and the byte
  // offset is naturally aligned for its size. Unsigned variants exist only
  // for loads, so a store using them is illegal.
  function automatic logic access_ok(input logic [2:0] f3,
                                     input logic [1:0] off,
                                     input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the byte/halfword lane out of a memory word and
// sign- or zero-extends it to 32 bits. Purely combinational (0 cycles).
// Ports: word_i (stored word), off_i (byte offset), funct3_i (size/sign),
// data_o (extended result; 0 for encodings that are not loads).
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Halfword lane is chosen by off[1]; off[0] is checked elsewhere.
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// RV32I data memory: combinational loads, byte-lane synchronous stores,
// sticky capture of the first misaligned/illegal access. Loads 0 cycles,
// stores visible after 1 edge. No backpressure: every access completes.
// Ports: clk, reset (sync, active-high), mem_read/mem_write enables,
// funct3 size/sign, addr byte address, write_data store data,
// read_data load result, access_err, fault/fault_addr sticky fault record.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        access_err,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic          unused_addr_hi;

  // Upper address bits are ignored on purpose: the array aliases.
  assign widx           = addr[AW+1:2];
  assign off            = addr[1:0];
  assign unused_addr_hi = ^addr[31:AW+2];

  // When both enables are set the stricter store rules apply, so a combined
  // access with an unsigned funct3 is rejected as a whole.
  assign access_err = (mem_read | mem_write) & ~access_ok(funct3, off, mem_write);

  // ---------------- load path ----------------
  logic [31:0] rd_word;
  logic [31:0] aligned_data;

  assign rd_word = mem_q[widx];

  load_align u_load_align (
    .word_i   (rd_word),
    .off_i    (off),
    .funct3_i (funct3),
    .data_o   (aligned_data)
  );

  assign read_data = (mem_read & ~access_err & ~reset) ? aligned_data : 32'h0;

  // ---------------- store path ----------------
  logic [3:0]  lane_we;
  logic [31:0] wdata_lanes;
  logic        store_en;

  // Store data is replicated across lanes so each lane enable can pick its
  // byte straight from the same bit positions.
  always_comb begin
    lane_we     = 4'b0000;
    wdata_lanes = write_data;
    case (funct3)
      F3_B: begin
        lane_we     = 4'b0001 << off;
        wdata_lanes = {4{write_data[7:0]}};
      end
      F3_H: begin
        lane_we     = off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{write_data[15:0]}};
      end
      F3_W:    lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  end

  assign store_en = mem_write & ~access_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_we[l]) begin
          mem_q[widx][8*l +: 8] <= wdata_lanes[8*l +: 8];
        end
      end
    end
  end

  // ---------------- fault capture ----------------
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  // Only the first erroneous access is recorded; later ones are ignored
  // until reset.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (access_err && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: load expectations go through a
// scoreboard queue, pushed when the access is driven and popped when
// read_data is sampled on the falling edge.
module tb_data_memory;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        access_err;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  data_memory #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .access_err (access_err),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all request inputs at once (called just after a rising edge).
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    write_data = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, W, 32'h0, 32'h0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b0, 1'b1, f3, a, wd);
    next_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    logic [31:0] addrs [3];
    addrs[0] = 32'h000; addrs[1] = 32'h040; addrs[2] = 32'h3FC;
    reset = 1'b1;
    drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    // Load enabled while reset is held must still read as zero.
    drive(1'b1, 1'b0, W, 32'h0, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL rst_read_data got %h want %h", read_data, exp);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL rst_fault got %b want 0", fault);
    end
    checks++;
    if (fault_addr !== 32'h0) begin
      errors++; $display("FAIL rst_fault_addr got %h want 0", fault_addr);
    end
    next_cycle();
    reset = 1'b0;
    foreach (addrs[i]) begin
      drive(1'b1, 1'b0, W, addrs[i], 32'h0);
      exp_q.push_back(32'h0);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (read_data !== exp || fault !== 1'b0) begin
        errors++;
        $display("FAIL rst_lw_%h got %h fault %b want %h fault 0", addrs[i], read_data, fault, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [6];
    logic [31:0] adrs [6];
    logic [31:0] exps [6];
    logic [31:0] exp;
    f3s[0] = B;  adrs[0] = 32'h10; exps[0] = 32'h00000001;
    f3s[1] = B;  adrs[1] = 32'h12; exps[1] = 32'hFFFFFFF1;
    f3s[2] = BU; adrs[2] = 32'h12; exps[2] = 32'h000000F1;
    f3s[3] = H;  adrs[3] = 32'h12; exps[3] = 32'hFFFF80F1;
    f3s[4] = HU; adrs[4] = 32'h12; exps[4] = 32'h000080F1;
    f3s[5] = W;  adrs[5] = 32'h10; exps[5] = 32'h80F17F01;
    do_store(W, 32'h10, 32'h80F17F01);
    foreach (f3s[i]) begin
      drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
      exp_q.push_back(exps[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (read_data !== exp || access_err !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d f3=%b @%h got %h err %b want %h err 0",
                 i, f3s[i], adrs[i], read_data, access_err, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] exp;
    do_store(W, 32'h20, 32'h11223344);
    do_store(B, 32'h21, 32'hFFFFFFAA);
    drive(1'b1, 1'b0, W, 32'h20, 32'h0);
    exp_q.push_back(32'h1122AA44);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL sb_lane got %h want %h", read_data, exp);
    end
    next_cycle();
    do_store(H, 32'h22, 32'h1234BEEF);
    drive(1'b1, 1'b0, W, 32'h20, 32'h0);
    exp_q.push_back(32'hBEEFAA44);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL sh_lane got %h want %h", read_data, exp);
    end
    next_cycle();
  endtask

  task automatic test_fault();
    logic [31:0] exp;
    do_store(W, 32'h04, 32'hCAFEF00D);
    drive(1'b0, 1'b1, W, 32'h06, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (access_err !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL misaligned_sw err %b fault %b want err 1 fault 0", access_err, fault);
    end
    next_cycle();
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h06) begin
      errors++; $display("FAIL fault_capture fault %b addr %h want 1 00000006", fault, fault_addr);
    end
    drive(1'b1, 1'b0, W, 32'h04, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL misaligned_no_write got %h want %h", read_data, exp);
    end
    next_cycle();
    drive(1'b1, 1'b0, H, 32'h31, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (access_err !== 1'b1 || read_data !== exp) begin
      errors++; $display("FAIL misaligned_lh err %b data %h want err 1 data %h", access_err, read_data, exp);
    end
    next_cycle();
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h06) begin
      errors++; $display("FAIL fault_sticky fault %b addr %h want 1 00000006", fault, fault_addr);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || fault_addr !== 32'h0) begin
      errors++; $display("FAIL fault_clear fault %b addr %h want 0 00000000", fault, fault_addr);
    end
    drive(1'b1, 1'b0, W, 32'h04, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL reset_clears_mem got %h want %h", read_data, exp);
    end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic [31:0] exp;
    do_store(W, 32'h60, 32'h01020304);
    drive(1'b0, 1'b1, BU, 32'h60, 32'hFFFFFFFF);
    @(negedge clk);
    checks++;
    if (access_err !== 1'b1) begin
      errors++; $display("FAIL sbu_illegal err %b want 1", access_err);
    end
    next_cycle();
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h60) begin
      errors++; $display("FAIL sbu_fault fault %b addr %h want 1 00000060", fault, fault_addr);
    end
    drive(1'b1, 1'b0, W, 32'h60, 32'h0);
    exp_q.push_back(32'h01020304);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL sbu_no_write got %h want %h", read_data, exp);
    end
    next_cycle();
    drive(1'b1, 1'b0, 3'b011, 32'h60, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (access_err !== 1'b1 || read_data !== exp) begin
      errors++; $display("FAIL f3_011_load err %b data %h want err 1 data %h", access_err, read_data, exp);
    end
    next_cycle();
    drive(1'b0, 1'b0, 3'b011, 32'h61, 32'h0);
    @(negedge clk);
    checks++;
    if (access_err !== 1'b0) begin
      errors++; $display("FAIL idle_no_err err %b want 0", access_err);
    end
    next_cycle();
    drive(1'b1, 1'b0, BU, 32'h63, 32'h0);
    exp_q.push_back(32'h00000001);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL lbu_lane3 got %h want %h", read_data, exp);
    end
    next_cycle();
    drive(1'b1, 1'b0, HU, 32'h62, 32'h0);
    exp_q.push_back(32'h00000102);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL lhu_upper got %h want %h", read_data, exp);
    end
    next_cycle();
  endtask

  task automatic test_hazards();
    logic [31:0] exp;
    do_reset();
    // Combined read+write: old contents now, new contents after the edge.
    drive(1'b1, 1'b1, W, 32'h50, 32'h12345678);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp || access_err !== 1'b0) begin
      errors++; $display("FAIL rw_same_cycle got %h err %b want %h err 0", read_data, access_err, exp);
    end
    next_cycle();
    drive(1'b1, 1'b0, W, 32'h50, 32'h0);
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL rw_next_cycle got %h want %h", read_data, exp);
    end
    next_cycle();
    do_store(W, 32'h400, 32'h0BADCAFE);
    drive(1'b1, 1'b0, W, 32'h000, 32'h0);
    exp_q.push_back(32'h0BADCAFE);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL alias_wrap got %h want %h", read_data, exp);
    end
    next_cycle();
    // Store and misaligned access while reset is high are both discarded.
    reset = 1'b1;
    drive(1'b0, 1'b1, W, 32'h70, 32'h00000077);
    next_cycle();
    drive(1'b0, 1'b1, W, 32'h72, 32'hFFFFFFFF);
    next_cycle();
    reset = 1'b0;
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL reset_blocks_fault fault %b want 0", fault);
    end
    drive(1'b1, 1'b0, W, 32'h70, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (read_data !== exp) begin
      errors++; $display("FAIL reset_drops_store got %h want %h", read_data, exp);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_lanes();
    test_fault();
    test_illegal();
    test_hazards();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
